// File: rtl/note_sequencer_pkg.sv
// Mode encodings and default timing shared by the note sequencer and the keyboard decode.
package note_sequencer_pkg;

  typedef enum logic [1:0] {
    MODE_CLAMP  = 2'b00,
    MODE_WRAP   = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  // 0.5 s per beat at 100 MHz
  localparam int DEFAULT_BASE_TICKS = 50_000_000;

endpackage

// File: rtl/note_sequencer_if.sv
// Command pulses from the keyboard decode and the sequencer state fed to the tone lookup.
interface note_sequencer_if #(
  parameter int NOTE_W = 5,
  parameter int SPD_W  = 2
) ();

  logic                      asc;
  logic                      dsc;
  logic                      fast;
  logic                      slow;
  logic                      pause;
  note_sequencer_pkg::mode_e mode;
  logic [NOTE_W-1:0]         note_idx;
  logic                      dir;
  logic [SPD_W-1:0]          speed;
  logic                      beat;
  logic                      at_end;

  modport master (
    output asc, dsc, fast, slow, pause, mode,
    input  note_idx, dir, speed, beat, at_end
  );

  modport slave (
    input  asc, dsc, fast, slow, pause, mode,
    output note_idx, dir, speed, beat, at_end
  );

endinterface

// File: rtl/note_sequencer_beat_timer.sv
// Beat period counter: step pulses combinationally on the last tick of each period.
// No backpressure; pause freezes the count, clr restarts it and masks that edge's step.
module note_sequencer_beat_timer #(
  parameter int BASE_TICKS = note_sequencer_pkg::DEFAULT_BASE_TICKS,
  parameter int NUM_SPEEDS = 4,
  parameter int SPD_W      = 2,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pause,
  input  logic [SPD_W-1:0] speed,
  input  logic             clr,
  output logic             step
);

  localparam longint unsigned MAX_PERIOD = longint'(BASE_TICKS) * longint'(NUM_SPEEDS);

  if (CNT_W < 64 && MAX_PERIOD > (64'd1 << CNT_W)) begin : g_cnt_w_too_small
    $error("note_sequencer_beat_timer: CNT_W too narrow for BASE_TICKS*NUM_SPEEDS");
  end

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] period_m1;
  logic             last_tick;

  assign period_m1 = CNT_W'(BASE_TICKS) * (CNT_W'(speed) + CNT_W'(1)) - CNT_W'(1);
  assign last_tick = (cnt == period_m1);
  assign step      = last_tick & ~pause & ~clr;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (!pause) begin
      cnt <= last_tick ? '0 : cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// Steps a note index once per beat in clamp/wrap/bounce/hold modes; beat strobes one cycle after each step.
// No backpressure: command pulses are consumed in the cycle they arrive, pause is a level.
module note_sequencer
  import note_sequencer_pkg::*;
#(
  parameter int NOTE_W     = 5,
  parameter int NUM_NOTES  = 29,
  parameter int BASE_TICKS = DEFAULT_BASE_TICKS,
  parameter int NUM_SPEEDS = 4,
  parameter int SPD_W      = 2,
  parameter int CNT_W      = 32
) (
  input logic              clk,
  input logic              rst,
  note_sequencer_if.slave  bus
);

  localparam logic [NOTE_W-1:0] TOP_IDX = NOTE_W'(NUM_NOTES - 1);
  localparam logic [NOTE_W-1:0] ONE     = NOTE_W'(1);
  localparam logic [SPD_W-1:0]  SPD_MAX = SPD_W'(NUM_SPEEDS - 1);

  logic              step;
  logic              spd_up;
  logic              spd_dn;
  logic              spd_chg;
  logic              at_top;
  logic              at_bot;
  logic [NOTE_W-1:0] note_fwd;
  logic [NOTE_W-1:0] note_back;
  logic [NOTE_W-1:0] note_nxt;
  logic              dir_nxt;

  // Opposing speed requests cancel; saturated requests leave the beat phase alone
  assign spd_dn  = bus.fast & ~bus.slow & (bus.speed != '0);
  assign spd_up  = bus.slow & ~bus.fast & (bus.speed != SPD_MAX);
  assign spd_chg = spd_up | spd_dn;

  note_sequencer_beat_timer #(
    .BASE_TICKS (BASE_TICKS),
    .NUM_SPEEDS (NUM_SPEEDS),
    .SPD_W      (SPD_W),
    .CNT_W      (CNT_W)
  ) u_beat_timer (
    .clk   (clk),
    .rst   (rst),
    .pause (bus.pause),
    .speed (bus.speed),
    .clr   (spd_chg),
    .step  (step)
  );

  assign at_top     = (bus.note_idx == TOP_IDX);
  assign at_bot     = (bus.note_idx == '0);
  assign bus.at_end = (bus.dir & at_top) | (~bus.dir & at_bot);

  assign note_fwd  = bus.dir ? bus.note_idx + ONE : bus.note_idx - ONE;
  assign note_back = bus.dir ? bus.note_idx - ONE : bus.note_idx + ONE;

  always_comb begin
    note_nxt = bus.note_idx;
    dir_nxt  = bus.dir;
    // A single position has nowhere to move, in any mode
    if (step && NUM_NOTES > 1) begin
      case (bus.mode)
        MODE_CLAMP: begin
          if (!bus.at_end) note_nxt = note_fwd;
        end
        MODE_WRAP: begin
          if (bus.at_end) note_nxt = bus.dir ? '0 : TOP_IDX;
          else            note_nxt = note_fwd;
        end
        MODE_BOUNCE: begin
          if (bus.at_end) begin
            note_nxt = note_back;
            dir_nxt  = ~bus.dir;
          end else begin
            note_nxt = note_fwd;
          end
        end
        default: note_nxt = bus.note_idx;
      endcase
    end
    // Explicit direction commands take priority over a bounce turnaround
    if (bus.asc)      dir_nxt = 1'b1;
    else if (bus.dsc) dir_nxt = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.note_idx <= '0;
      bus.dir      <= 1'b1;
      bus.speed    <= '0;
      bus.beat     <= 1'b0;
    end else begin
      bus.note_idx <= note_nxt;
      bus.dir      <= dir_nxt;
      bus.beat     <= step;
      if (spd_up)      bus.speed <= bus.speed + SPD_W'(1);
      else if (spd_dn) bus.speed <= bus.speed - SPD_W'(1);
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Directed scenarios plus random commands, checked every cycle against a beat-level model.
module tb_note_sequencer;
  import note_sequencer_pkg::*;

  localparam int NOTE_W     = 3;
  localparam int NUM_NOTES  = 5;
  localparam int BASE_TICKS = 4;
  localparam int NUM_SPEEDS = 4;
  localparam int SPD_W      = 2;
  localparam int CNT_W      = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  note_sequencer_if #(.NOTE_W(NOTE_W), .SPD_W(SPD_W)) bus ();

  note_sequencer #(
    .NOTE_W     (NOTE_W),
    .NUM_NOTES  (NUM_NOTES),
    .BASE_TICKS (BASE_TICKS),
    .NUM_SPEEDS (NUM_SPEEDS),
    .SPD_W      (SPD_W),
    .CNT_W      (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: ticks elapsed in the current beat, plus the musical state
  int m_note, m_dir, m_speed, m_elapsed, m_beat;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    int d, tgt;
    bit stepped, flip;
    if (rst) begin
      m_note = 0; m_dir = 1; m_speed = 0; m_elapsed = 0; m_beat = 0;
      return;
    end
    stepped = 0;
    flip    = 0;
    if (bus.fast && !bus.slow && m_speed > 0) begin
      m_speed--; m_elapsed = 0;
    end else if (bus.slow && !bus.fast && m_speed < NUM_SPEEDS - 1) begin
      m_speed++; m_elapsed = 0;
    end else if (!bus.pause) begin
      m_elapsed++;
      if (m_elapsed == BASE_TICKS * (m_speed + 1)) begin
        stepped = 1; m_elapsed = 0;
      end
    end
    m_beat = stepped;
    if (stepped) begin
      d   = m_dir ? 1 : -1;
      tgt = m_note + d;
      case (bus.mode)
        MODE_CLAMP:  if (tgt >= 0 && tgt < NUM_NOTES) m_note = tgt;
        MODE_WRAP:   m_note = (tgt + NUM_NOTES) % NUM_NOTES;
        MODE_BOUNCE: begin
          if (tgt >= 0 && tgt < NUM_NOTES) m_note = tgt;
          else if (NUM_NOTES > 1) begin m_note = m_note - d; flip = 1; end
        end
        default: ;
      endcase
    end
    if (bus.asc)      m_dir = 1;
    else if (bus.dsc) m_dir = 0;
    else if (flip)    m_dir = 1 - m_dir;
  endtask

  // One clock: model follows the edge, outputs checked at the falling edge, pulses dropped
  task automatic cyc();
    int exp_end;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    exp_end = ((m_dir == 1 && m_note == NUM_NOTES - 1) || (m_dir == 0 && m_note == 0)) ? 1 : 0;
    chk("note_idx", 64'(bus.note_idx), 64'(m_note));
    chk("dir",      64'(bus.dir),      64'(m_dir));
    chk("speed",    64'(bus.speed),    64'(m_speed));
    chk("beat",     64'(bus.beat),     64'(m_beat));
    chk("at_end",   64'(bus.at_end),   64'(exp_end));
    bus.asc = 0; bus.dsc = 0; bus.fast = 0; bus.slow = 0;
  endtask

  task automatic wait_beat(output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!bus.beat && n < 40);
    if (!bus.beat) chk("beat_timeout", 64'(0), 64'(1));
  endtask

  int n, held;
  int t1_note[6] = '{1, 2, 3, 4, 4, 4};
  int t2_note[5] = '{0, 1, 0, 4, 3};
  int t3_note[3] = '{4, 3, 2};
  int t3_dir[3]  = '{1, 0, 0};

  initial begin
    rst = 1;
    bus.asc = 0; bus.dsc = 0; bus.fast = 0; bus.slow = 0; bus.pause = 0;
    bus.mode = MODE_CLAMP;
    cyc(); cyc();
    chk("rst_note",  64'(bus.note_idx), 64'(0));
    chk("rst_dir",   64'(bus.dir),      64'(1));
    chk("rst_speed", 64'(bus.speed),    64'(0));
    chk("rst_beat",  64'(bus.beat),     64'(0));
    rst = 0;

    // Clamp: one step per 4 cycles, parks at the top
    for (int i = 0; i < 6; i++) begin
      wait_beat(n);
      chk("t1_period", 64'(n), 64'(4));
      chk("t1_note", 64'(bus.note_idx), 64'(t1_note[i]));
    end
    chk("t1_at_end", 64'(bus.at_end), 64'(1));

    // Wrap, then reverse
    bus.mode = MODE_WRAP;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        bus.dsc = 1; cyc();
        chk("t2_dsc_dir", 64'(bus.dir), 64'(0));
      end
      wait_beat(n);
      chk("t2_note", 64'(bus.note_idx), 64'(t2_note[i]));
    end

    // Bounce off the top, then an asc on the turnaround edge keeps dir
    bus.mode = MODE_BOUNCE;
    bus.asc = 1; cyc();
    chk("t3_asc_dir", 64'(bus.dir), 64'(1));
    for (int i = 0; i < 3; i++) begin
      wait_beat(n);
      chk("t3_note", 64'(bus.note_idx), 64'(t3_note[i]));
      chk("t3_dir",  64'(bus.dir),      64'(t3_dir[i]));
    end
    bus.asc = 1; cyc();
    wait_beat(n); wait_beat(n);
    chk("t3_top", 64'(bus.note_idx), 64'(4));
    cyc(); cyc(); cyc();
    bus.asc = 1; cyc();
    chk("t3_override_note", 64'(bus.note_idx), 64'(3));
    chk("t3_override_dir",  64'(bus.dir),      64'(1));
    wait_beat(n);

    // Speed changes restart the beat; saturated or conflicting requests do nothing
    bus.mode = MODE_HOLD;
    cyc(); cyc();
    bus.slow = 1; cyc();
    chk("t4_slow_speed", 64'(bus.speed), 64'(1));
    wait_beat(n);
    chk("t4_slow_period", 64'(n), 64'(8));
    bus.fast = 1; cyc();
    wait_beat(n);
    chk("t4_fast_period", 64'(n), 64'(4));
    cyc();
    bus.fast = 1; cyc();
    chk("t4_fast_sat", 64'(bus.speed), 64'(0));
    wait_beat(n);
    chk("t4_fast_sat_period", 64'(n), 64'(2));
    bus.fast = 1; bus.slow = 1; cyc();
    chk("t4_both_speed", 64'(bus.speed), 64'(0));
    wait_beat(n);
    chk("t4_both_period", 64'(n), 64'(3));

    // Pause freezes the beat phase; direction still accepted
    bus.mode = MODE_CLAMP;
    bus.dsc = 1; cyc();
    cyc();
    held = int'(bus.note_idx);
    bus.pause = 1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 3) bus.asc = 1;
      cyc();
      if (bus.beat) n++;
    end
    chk("t5_pause_beats", 64'(n), 64'(0));
    chk("t5_pause_note",  64'(bus.note_idx), 64'(held));
    chk("t5_pause_dir",   64'(bus.dir), 64'(1));
    bus.pause = 0;
    wait_beat(n);
    chk("t5_resume", 64'(n), 64'(2));

    // Reset mid-beat from a non-reset state
    bus.slow = 1; cyc();
    bus.slow = 1; cyc();
    bus.dsc = 1; cyc();
    cyc(); cyc();
    chk("t6_pre_speed", 64'(bus.speed), 64'(2));
    rst = 1; bus.asc = 1; bus.fast = 1;
    cyc();
    rst = 0;
    chk("t6_rst_note",  64'(bus.note_idx), 64'(0));
    chk("t6_rst_dir",   64'(bus.dir),      64'(1));
    chk("t6_rst_speed", 64'(bus.speed),    64'(0));
    chk("t6_rst_beat",  64'(bus.beat),     64'(0));
    wait_beat(n);
    chk("t6_first_beat", 64'(n), 64'(4));
    bus.dsc = 1; cyc();
    chk("t6_dsc", 64'(bus.dir), 64'(0));
    bus.asc = 1; bus.dsc = 1; cyc();
    chk("t6_asc_wins", 64'(bus.dir), 64'(1));

    // Random commands against the model
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 299) == 0);
      bus.asc  = ($urandom_range(0, 15) == 0);
      bus.dsc  = ($urandom_range(0, 15) == 0);
      bus.fast = ($urandom_range(0, 23) == 0);
      bus.slow = ($urandom_range(0, 23) == 0);
      if ($urandom_range(0, 19) == 0) bus.pause = ~bus.pause;
      if ($urandom_range(0, 29) == 0) bus.mode = mode_e'($urandom_range(0, 3));
      cyc();
    end
    rst = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
